ls_unit: RTL and testbench

//  Load/store sequencer between the core's execute stage and the 8-bit data memory.
//  - Accepts one byte or 16-bit (wide) load/store request through a valid/ready handshake.
//  - Drives the memory's address, ReadMem, WriteMem and DataIn; captures DataOut.
//  - Returns the result through a valid/ready response handshake.
//  - Wide accesses are split into two byte cycles, little-endian.

---
 rtl/ls_pkg.sv | 9 +
 rtl/ls_unit.sv | 139 +++++++++++++
 tb/tb_ls_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared types and widths for the load/store sequencer
package ls_pkg;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} ls_state_t;

  localparam int MEM_DW = 8;
  localparam int REQ_DW = 16;

endpackage

// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - byte/wide load-store sequencer to 8-bit memory; LS_ALIGN_CHECK_EN enables misaligned-wide rejection
module ls_unit
  import ls_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              CLK,
  input  logic              RstN,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              ReqWide,
  input  logic [AW-1:0]     ReqAdr,
  input  logic [REQ_DW-1:0] ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [REQ_DW-1:0] RspData,
  output logic              RspErr,
  output logic [AW-1:0]     MemAdr,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [MEM_DW-1:0] MemDataIn,
  input  logic [MEM_DW-1:0] MemDataOut
);

  ls_state_t         state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [REQ_DW-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic              wide_q, wide_d;
  logic [REQ_DW-1:0] rsp_data_q, rsp_data_d;
`ifdef LS_ALIGN_CHECK_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      wide_q     <= 1'b0;
      rsp_data_q <= '0;
`ifdef LS_ALIGN_CHECK_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      wide_q     <= wide_d;
      rsp_data_q <= rsp_data_d;
`ifdef LS_ALIGN_CHECK_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Next-state: latch request on accept, capture load bytes at the closing edge of each access cycle
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    data_d     = data_q;
    write_d    = write_q;
    wide_d     = wide_q;
    rsp_data_d = rsp_data_q;
`ifdef LS_ALIGN_CHECK_EN
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          adr_d      = ReqAdr;
          data_d     = ReqData;
          write_d    = ReqWrite;
          wide_d     = ReqWide;
          rsp_data_d = '0;
          state_d    = ACC0;
`ifdef LS_ALIGN_CHECK_EN
          rsp_err_d  = 1'b0;
          if (ReqWide && ReqAdr[0]) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end
`endif
        end
      end
      ACC0: begin
        if (!write_q) rsp_data_d[MEM_DW-1:0] = MemDataOut;
        state_d = wide_q ? ACC1 : RESP;
      end
      ACC1: begin
        if (!write_q) rsp_data_d[REQ_DW-1:MEM_DW] = MemDataOut;
        state_d = RESP;
      end
      RESP: begin
        if (RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from state and latched request only
  always_comb begin
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    ReadMem   = 1'b0;
    WriteMem  = 1'b0;
    MemAdr    = '0;
    MemDataIn = '0;
    case (state_q)
      IDLE: ReqReady = 1'b1;
      ACC0: begin
        MemAdr    = adr_q;
        ReadMem   = !write_q;
        WriteMem  = write_q;
        MemDataIn = write_q ? data_q[MEM_DW-1:0] : '0;
      end
      ACC1: begin
        MemAdr    = adr_q + {{(AW-1){1'b0}}, 1'b1};
        ReadMem   = !write_q;
        WriteMem  = write_q;
        MemDataIn = write_q ? data_q[REQ_DW-1:MEM_DW] : '0;
      end
      RESP: RspValid = 1'b1;
      default: ReqReady = 1'b0;
    endcase
  end

  assign RspData = rsp_data_q;
`ifdef LS_ALIGN_CHECK_EN
  assign RspErr = rsp_err_q;
`else
  assign RspErr = 1'b0;
`endif

endmodule

// File: tb/tb_ls_unit.sv
// tb/tb_ls_unit.sv - directed bench for ls_unit with a behavioural 8-bit data memory
module tb_ls_unit;

  logic        CLK = 1'b0;
  logic        RstN;
  logic        ReqValid, ReqReady, ReqWrite, ReqWide;
  logic [7:0]  ReqAdr;
  logic [15:0] ReqData;
  logic        RspValid, RspReady, RspErr;
  logic [15:0] RspData;
  logic [7:0]  MemAdr, MemDataIn;
  wire  [7:0]  MemDataOut;
  logic        ReadMem, WriteMem;

  logic [7:0]  mem [256];
  logic        pre_we;
  logic [7:0]  pre_adr, pre_dat;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ls_unit #(.AW(8)) dut (
    .CLK(CLK), .RstN(RstN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqWide(ReqWide),
    .ReqAdr(ReqAdr), .ReqData(ReqData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .MemAdr(MemAdr), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  assign MemDataOut = ReadMem ? mem[MemAdr] : 8'hzz;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_adr] <= pre_dat;
    else if (WriteMem) mem[MemAdr] <= MemDataIn;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_adr = a; pre_dat = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Present one request in IDLE, count edges until RspValid, then consume the response
  task automatic do_req(input logic wr, input logic wd, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rdata, output logic err);
    ReqWrite = wr; ReqWide = wd; ReqAdr = a; ReqData = d; ReqValid = 1'b1;
    lat = 0;
    do begin
      tick();
      ReqValid = 1'b0;
      lat++;
    end while (!RspValid && lat < 10);
    rdata = RspData;
    err = RspErr;
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
  endtask

  int          lat;
  logic [15:0] rd;
  logic        er;
  logic [15:0] exp_b2b [3];

  initial begin
    RstN = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAdr = '0; ReqData = '0;
    RspReady = 1'b0; pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
    tick();
    check("rst_req_ready", ReqReady, 1);
    check("rst_rsp_valid", RspValid, 0);
    check("rst_rsp_data", RspData, 0);
    check("rst_rsp_err", RspErr, 0);
    check("rst_mem_ctrl", {ReadMem, WriteMem}, 0);
    check("rst_mem_adr", MemAdr, 0);
    check("rst_mem_din", MemDataIn, 0);

    preload(8'h10, 8'h00); preload(8'h20, 8'h00); preload(8'h21, 8'h00);
    preload(8'h00, 8'h55); preload(8'hFF, 8'h66); preload(8'h40, 8'h00);
    preload(8'h41, 8'h77); preload(8'h50, 8'h44);
    preload(8'h30, 8'h11); preload(8'h31, 8'h22); preload(8'h32, 8'h33);
    RstN = 1'b1;
    tick();

    // 1: byte store then byte load
    do_req(1'b1, 1'b0, 8'h10, 16'h77A5, lat, rd, er);
    check("bst_lat", lat, 2);
    check("bst_data", rd, 16'h0000);
    check("bst_mem", mem[8'h10], 8'hA5);
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, lat, rd, er);
    check("bld_lat", lat, 2);
    check("bld_data", rd, 16'h00A5);
    check("bld_err", er, 0);

    // 2: wide store then wide load
    do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, lat, rd, er);
    check("wst_lat", lat, 3);
    check("wst_mem_lo", mem[8'h20], 8'hEF);
    check("wst_mem_hi", mem[8'h21], 8'hBE);
    do_req(1'b0, 1'b1, 8'h20, 16'h0000, lat, rd, er);
    check("wld_lat", lat, 3);
    check("wld_data", rd, 16'hBEEF);

    // 3: misaligned wide store at top of memory
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234, lat, rd, er);
`ifdef LS_ALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_err", er, 1);
    check("mis_data", rd, 0);
    check("mis_mem_ff", mem[8'hFF], 8'h66);
    check("mis_mem_00", mem[8'h00], 8'h55);
`else
    check("wrap_lat", lat, 3);
    check("wrap_err", er, 0);
    check("wrap_mem_ff", mem[8'hFF], 8'h34);
    check("wrap_mem_00", mem[8'h00], 8'h12);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000, lat, rd, er);
    check("wrap_ld_data", rd, 16'h1234);
`endif

    // 4: response stall with a competing request held
    ReqWrite = 1'b0; ReqWide = 1'b0; ReqAdr = 8'h10; ReqValid = 1'b1;
    tick();
    ReqWrite = 1'b1; ReqAdr = 8'h50; ReqData = 16'h0099;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", RspValid, 1);
      check("stall_data", RspData, 16'h00A5);
      check("stall_req_ready", ReqReady, 0);
      check("stall_wmem", WriteMem, 0);
      tick();
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    check("stall_done_ready", ReqReady, 1);
    check("stall_done_valid", RspValid, 0);
    tick(); tick(); tick();
    check("stall_mem50", mem[8'h50], 8'h44);

    // 5: reset during the second byte of a wide store
    ReqWrite = 1'b1; ReqWide = 1'b1; ReqAdr = 8'h40; ReqData = 16'hCAFE; ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    check("abort_acc1_wmem", WriteMem, 1);
    check("abort_acc1_adr", MemAdr, 8'h41);
    RstN = 1'b0;
    #1;
    check("abort_wmem", WriteMem, 0);
    check("abort_ready", ReqReady, 1);
    check("abort_adr", MemAdr, 0);
    tick();
    check("abort_rsp_valid", RspValid, 0);
    RstN = 1'b1;
    tick();
    check("abort_mem40", mem[8'h40], 8'hFE);
    check("abort_mem41", mem[8'h41], 8'h77);

    // 6: back-to-back byte loads, RspReady tied high
    exp_b2b[0] = 16'h0011; exp_b2b[1] = 16'h0022; exp_b2b[2] = 16'h0033;
    RspReady = 1'b1; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAdr = 8'h30; ReqValid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      case (k % 3)
        1: begin
          check("b2b_acc_rd", ReadMem, 1);
          check("b2b_acc_adr", MemAdr, 8'h30 + 8'((k - 1) / 3));
          check("b2b_acc_valid", RspValid, 0);
        end
        2: begin
          check("b2b_rsp_valid", RspValid, 1);
          check("b2b_rsp_rd", ReadMem, 0);
          check("b2b_rsp_data", RspData, exp_b2b[(k - 2) / 3]);
        end
        default: begin
          check("b2b_idle_ready", ReqReady, 1);
          check("b2b_idle_rd", ReadMem, 0);
          check("b2b_idle_valid", RspValid, 0);
          ReqAdr = ReqAdr + 8'h01;
          if (k == 9) ReqValid = 1'b0;
        end
      endcase
    end
    RspReady = 1'b0;
    tick();
    check("end_idle", ReqReady, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
